// File: rtl/fp_mul_if.sv
// Handshake and data bundle for the sequential fixed-point multiplier.
// The master side issues start with operands x/y. The slave side returns busy/valid/ovf and the product p.
interface fp_mul_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             busy;
  logic             valid;
  logic             ovf;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] p;

  modport master (output start, x, y, input busy, valid, ovf, p);
  modport slave  (input start, x, y, output busy, valid, ovf, p);
endinterface

// File: rtl/fp_mul.sv
// Sequential signed fixed-point multiplier, Q(WIDTH-FBITS).FBITS.
// The operand magnitudes are multiplied by shift-and-add, one multiplicand bit per clock.
// The latency is fixed at WIDTH steps.
// The 2*WIDTH-bit product is rescaled by FBITS and truncated toward zero.
// The sign is then restored, and the result saturates when it leaves the signed range.
module fp_mul #(
  parameter int WIDTH = 32,
  parameter int FBITS = 24
) (
  input  logic      clk,
  input  logic      rst_n,
  fp_mul_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;     // |x|, consumed LSB first
  logic [2*WIDTH-1:0] mplier_q, mplier_d;   // |y| << i, kept pre-shifted
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   p_q, p_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;

  // Operand magnitudes; |most-negative| = 2^(WIDTH-1) still fits unsigned.
  logic [WIDTH-1:0]   abs_x, abs_y;
  // Product including the current step, and its rescaled view.
  logic [2*WIDTH-1:0] prod, prod_hi;
  logic [WIDTH:0]     upper;                // prod bits [2W-1 : FBITS+W-1]
  logic [WIDTH-1:0]   m;
  logic               is_min, ovf_det;
  logic [WIDTH-1:0]   sat_val;

  // Magnitudes, partial product and the rescale/saturation decode.
  always_comb begin
    abs_x   = bus.x[WIDTH-1] ? (-bus.x) : bus.x;
    abs_y   = bus.y[WIDTH-1] ? (-bus.y) : bus.y;
    prod    = acc_q + (mcand_q[0] ? mplier_q : '0);
    prod_hi = prod >> FBITS;
    m       = prod_hi[WIDTH-1:0];
    upper   = prod_hi[2*WIDTH-1:WIDTH-1];
    // Exactly -2^(WIDTH-1) is representable, so it is not an overflow.
    is_min  = neg_q && (upper == {{WIDTH{1'b0}}, 1'b1}) && (m[WIDTH-2:0] == '0);
    ovf_det = (|upper) && !is_min;
    sat_val = neg_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  // Next-state logic: start has priority and restarts even while busy.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    p_d      = p_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
    if (bus.start) begin
      state_d  = S_BUSY;
      neg_d    = bus.x[WIDTH-1] ^ bus.y[WIDTH-1];
      mcand_d  = abs_x;
      mplier_d = {{WIDTH{1'b0}}, abs_y};
      acc_d    = '0;
      cnt_d    = '0;
      valid_d  = 1'b0;
      ovf_d    = 1'b0;
    end else if (state_q == S_BUSY) begin
      acc_d    = prod;
      mcand_d  = mcand_q >> 1;
      mplier_d = mplier_q << 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH-1)) begin
        state_d = S_IDLE;
        valid_d = 1'b1;
        ovf_d   = ovf_det;
        p_d     = ovf_det ? sat_val : (neg_q ? (-m) : m);
      end
    end
  end

  // State register; reset abandons any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.busy  = (state_q == S_BUSY);
  assign bus.valid = valid_q;
  assign bus.ovf   = ovf_q;
  assign bus.p     = p_q;

endmodule

// File: tb/tb_fp_mul.sv
// Directed vector bench for fp_mul (WIDTH=32, FBITS=24, Q8.24).
module tb_fp_mul;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  fp_mul_if #(.WIDTH(32)) bus ();

  fp_mul #(.WIDTH(32), .FBITS(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] p;
    logic        ovf;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Counts rising edges after the start edge until valid; latency 32 expected.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_mul(input logic [31:0] xa, input logic [31:0] ya, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = xa;
    bus.y     = ya;
    @(negedge clk);
    bus.start = 1'b0;
    bus.x     = $urandom;
    bus.y     = $urandom;
    wait_valid(lat);
  endtask

  int          lat;
  logic [31:0] p_hold;

  initial begin
    tests = 0;
    fails = 0;
    bus.start = 1'b0;
    bus.x = '0;
    bus.y = '0;
    rst_n = 1'b1;

    vecs[0]  = '{32'h0180_0000, 32'h0200_0000, 32'h0300_0000, 1'b0}; //  1.5 * 2.0
    vecs[1]  = '{32'hFE80_0000, 32'h0200_0000, 32'hFD00_0000, 1'b0}; // -1.5 * 2.0
    vecs[2]  = '{32'h0000_0001, 32'h0080_0000, 32'h0000_0000, 1'b0}; // 2^-24 * 0.5
    vecs[3]  = '{32'hFFFF_FFFF, 32'h0080_0000, 32'h0000_0000, 1'b0}; // -2^-24 * 0.5, toward zero
    vecs[4]  = '{32'h8000_0000, 32'h0100_0000, 32'h8000_0000, 1'b0}; // -128 * 1.0
    vecs[5]  = '{32'h8000_0000, 32'hFF00_0000, 32'h7FFF_FFFF, 1'b1}; // -128 * -1.0
    vecs[6]  = '{32'h6400_0000, 32'h0200_0000, 32'h7FFF_FFFF, 1'b1}; //  100 * 2.0
    vecs[7]  = '{32'h9C00_0000, 32'h0200_0000, 32'h8000_0000, 1'b1}; // -100 * 2.0
    vecs[8]  = '{32'h0000_0000, 32'hFF00_0000, 32'h0000_0000, 1'b0}; //  0 * -1.0
    vecs[9]  = '{32'hFF80_0000, 32'hFF80_0000, 32'h0040_0000, 1'b0}; // -0.5 * -0.5
    vecs[10] = '{32'h0300_0000, 32'hFD80_0000, 32'hF880_0000, 1'b0}; //  3.0 * -2.5
    vecs[11] = '{32'h8000_0000, 32'h0080_0000, 32'hC000_0000, 1'b0}; // -128 * 0.5
    vecs[12] = '{32'hFFFF_FFFF, 32'h0180_0000, 32'hFFFF_FFFF, 1'b0}; // -1ulp * 1.5 -> -1ulp
    vecs[13] = '{32'h0000_0001, 32'h0180_0000, 32'h0000_0001, 1'b0}; //  1ulp * 1.5 -> 1ulp
    vecs[14] = '{32'h7FFF_FFFF, 32'h0100_0000, 32'h7FFF_FFFF, 1'b0}; //  max * 1.0

    // Reset state
    #3 rst_n = 1'b0;
    #1;
    check("reset_busy",  {31'd0, bus.busy},  32'd0);
    check("reset_valid", {31'd0, bus.valid}, 32'd0);
    check("reset_ovf",   {31'd0, bus.ovf},   32'd0);
    check("reset_p",     bus.p,              32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, issued back-to-back on the cycle valid is first seen
    for (int i = 0; i < 15; i++) begin
      do_mul(vecs[i].x, vecs[i].y, lat);
      $display("[TB] vec %0d x=%h y=%h p=%h ovf=%b lat=%0d", i, vecs[i].x, vecs[i].y, bus.p, bus.ovf, lat);
      check($sformatf("vec%0d_lat", i), lat, 32'd32);
      check($sformatf("vec%0d_p", i), bus.p, vecs[i].p);
      check($sformatf("vec%0d_ovf", i), {31'd0, bus.ovf}, {31'd0, vecs[i].ovf});
      check($sformatf("vec%0d_busy", i), {31'd0, bus.busy}, 32'd0);
    end

    // Restart: 3.0*3.0, then 2.0*0.25 sampled at cycle 10
    @(negedge clk);
    bus.start = 1'b1;
    bus.x = 32'h0300_0000;
    bus.y = 32'h0300_0000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("restart_busy_before", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b1;
    bus.x = 32'h0200_0000;
    bus.y = 32'h0040_0000;
    @(negedge clk);
    bus.start = 1'b0;
    wait_valid(lat);
    $display("[TB] restart p=%h ovf=%b lat=%0d", bus.p, bus.ovf, lat);
    check("restart_lat", lat, 32'd32);
    check("restart_p", bus.p, 32'h0080_0000);
    check("restart_ovf", {31'd0, bus.ovf}, 32'd0);

    // Result holds while idle
    p_hold = 32'h0080_0000;
    repeat (3) @(negedge clk);
    $display("[TB] hold p=%h valid=%b", bus.p, bus.valid);
    check("hold_p", bus.p, p_hold);
    check("hold_valid", {31'd0, bus.valid}, 32'd1);

    // Reset mid-operation at cycle 5
    @(negedge clk);
    bus.start = 1'b1;
    bus.x = 32'h0180_0000;
    bus.y = 32'h0200_0000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] midreset busy=%b valid=%b ovf=%b p=%h", bus.busy, bus.valid, bus.ovf, bus.p);
    check("midreset_busy",  {31'd0, bus.busy},  32'd0);
    check("midreset_valid", {31'd0, bus.valid}, 32'd0);
    check("midreset_ovf",   {31'd0, bus.ovf},   32'd0);
    check("midreset_p",     bus.p,              32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_mul(32'hFE80_0000, 32'h0200_0000, lat);
    $display("[TB] postreset p=%h ovf=%b lat=%0d", bus.p, bus.ovf, lat);
    check("postreset_lat", lat, 32'd32);
    check("postreset_p", bus.p, 32'hFD00_0000);
    check("postreset_ovf", {31'd0, bus.ovf}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
